vga_mem_arbiter: RTL
====================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 15, framebuffer address width (160x120 RGB332 = 19200 words).
REQ-002 Parameter DATA_W, 8, pixel width (RGB332: R[7:5] G[4:2] B[1:0]).
REQ-003 Parameter STARVE_LIMIT, 8, consecutive display grants with writer pending before writer is forced through.
REQ-004 i_clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset; assertion clears state immediately, release takes effect at the next rising edge.
REQ-006 i_disp_req  in  1  scan-out prefetch read request; held with i_disp_addr until o_disp_ack.
REQ-007 i_disp_addr  in  ADDR_W  scan-out read address.
REQ-008 o_disp_ack  out  1  one-cycle pulse: display request accepted.
REQ-009 o_disp_valid  out  1  one-cycle pulse: o_disp_data holds the pixel for the accepted read.
REQ-010 o_disp_data  out  DATA_W  read pixel.
REQ-011 i_wr_req  in  1  writer (switch/LED logic) request; held with addr/data until o_wr_ack.
REQ-012 i_wr_addr  in  ADDR_W; i_wr_data  in  DATA_W  write address and pixel.
REQ-013 o_wr_ack  out  1  one-cycle pulse: write accepted.
REQ-014 o_mem_addr  out  ADDR_W; o_mem_we  out  1; o_mem_wdata  out  DATA_W  single-port synchronous RAM port.
REQ-015 i_mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address edge.
REQ-016 o_disp_late  out  1  one-cycle pulse: display request pending but writer granted (forced slot).

Function
REQ-017 Exactly one RAM access per cycle; at each rising edge the arbiter SHALL grant at most one requester.
REQ-018 FSM states IDLE, GNT_DISP, GNT_WR record the grant issued at the last edge; no request -> IDLE; display grant -> GNT_DISP; writer grant -> GNT_WR.
REQ-019 Priority: display only -> display; writer only -> writer; both -> display unless starve_cnt == STARVE_LIMIT, then writer.
REQ-020 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on each edge granting display while i_wr_req=1, clear to 0 on writer grant or whenever i_wr_req=0, and never exceed STARVE_LIMIT.
REQ-021 Display grant at edge T: o_disp_ack=1, o_mem_addr<=i_disp_addr, o_mem_we<=0 during cycle T..T+1.
REQ-022 Display read latency: o_disp_valid=1 with o_disp_data=i_mem_rdata for exactly the cycle following edge T+2; reads complete in grant order.
REQ-023 Writer grant at edge T: o_wr_ack=1, o_mem_we<=1, o_mem_addr<=i_wr_addr, o_mem_wdata<=i_wr_data for one cycle only.
REQ-024 Forced writer grant while i_disp_req=1 SHALL pulse o_disp_late in the same cycle as o_wr_ack; display is then granted at the next edge if still requesting.
REQ-025 Idle cycle: o_mem_we=0, o_mem_addr and o_mem_wdata hold previous values, no ack pulses.
REQ-026 Back-to-back: a requester keeping req high after ack presents a new address; continuous display grants every edge are permitted (100% throughput without writer).
REQ-027 Read-after-write to the same address granted on consecutive edges SHALL return the new data (RAM write-first not required; write precedes read by one cycle).
REQ-028 All outputs registered; no combinational path from any input to any output.

Reset
REQ-029 While i_rst_n=0: state IDLE, starve_cnt=0, o_disp_ack=0, o_disp_valid=0, o_disp_data=0, o_wr_ack=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_disp_late=0.
REQ-030 Reset asserted with reads in flight SHALL discard them; no o_disp_valid after release for pre-reset grants.
REQ-031 First grant possible at the first rising edge after i_rst_n rises.

Verification
REQ-032 Display only, addrs 0..4 back-to-back, RAM[a]=a+0x10 -> acks on 5 consecutive edges, valids 2 edges later carrying 0x10..0x14 in order.
REQ-033 Writer only, addr 0x12C0 data 0xE3 -> single o_wr_ack, o_mem_we=1 one cycle, addr 0x12C0, wdata 0xE3.
REQ-034 Both held continuously, STARVE_LIMIT=8 -> 8 display acks, then 1 o_wr_ack with o_disp_late=1, repeating 8:1 pattern.
REQ-035 Write 0x1C to addr 5, then display read addr 5 next edge -> o_disp_data=0x1C.
REQ-036 i_rst_n pulsed low one edge after a display grant -> all outputs 0 immediately, no o_disp_valid afterwards, starve_cnt=0.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Single-port framebuffer arbiter: display reads win over the writer until the writer starves; read data returns 2 edges after o_disp_ack.
// Requests are held until acked, and grant order is also the order in which reads complete.
module vga_mem_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_ack,
  output logic              o_disp_valid,
  output logic [DATA_W-1:0] o_disp_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_disp_late
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GNT_DISP, GNT_WR} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_d;
  logic             grant_disp, grant_wr;
  logic             rd_stage2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      starve_cnt <= '0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  always_comb begin
    grant_disp   = 1'b0;
    grant_wr     = 1'b0;
    state_d      = IDLE;
    starve_cnt_d = starve_cnt;

    // Display wins ties unless the writer has already waited out its budget.
    if (i_disp_req && !(i_wr_req && starve_cnt == CNT_MAX)) begin
      grant_disp = 1'b1;
      state_d    = GNT_DISP;
    end else if (i_wr_req) begin
      grant_wr = 1'b1;
      state_d  = GNT_WR;
    end

    if (!i_wr_req || grant_wr) begin
      starve_cnt_d = '0;
    end else if (grant_disp && starve_cnt < CNT_MAX) begin
      starve_cnt_d = starve_cnt + CNT_W'(1);
    end
  end

  // GNT_DISP in state_q marks the read whose address the RAM samples this
  // edge; rd_stage2 marks the cycle its data sits on i_mem_rdata.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_disp_ack   <= 1'b0;
      o_wr_ack     <= 1'b0;
      o_disp_late  <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      rd_stage2    <= 1'b0;
      o_disp_valid <= 1'b0;
      o_disp_data  <= '0;
    end else begin
      o_disp_ack   <= grant_disp;
      o_wr_ack     <= grant_wr;
      o_disp_late  <= grant_wr & i_disp_req;
      o_mem_we     <= grant_wr;
      if (grant_disp) begin
        o_mem_addr <= i_disp_addr;
      end else if (grant_wr) begin
        o_mem_addr  <= i_wr_addr;
        o_mem_wdata <= i_wr_data;
      end
      rd_stage2    <= (state_q == GNT_DISP);
      o_disp_valid <= rd_stage2;
      if (rd_stage2) begin
        o_disp_data <= i_mem_rdata;
      end
    end
  end

endmodule
